condiciona_entrada: RTL and testbench

Input conditioner that sits directly upstream of the team's pulse-driven sequential counters.
- Takes a raw, asynchronous, bouncy push-button/switch level and synchronises it into the clk domain.
- Debounces it and emits a single-cycle `pulso` per accepted press, suitable for the downstream block's count-enable input.
- Also exports the debounced level and a busy flag.

---
 rtl/condiciona_pkg.sv | 15 +
 rtl/condiciona_entrada_if.sv | 13 +
 rtl/sincronizador.sv | 21 ++
 rtl/condiciona_entrada.sv | 95 +++++++++
 tb/tb_condiciona_entrada.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/condiciona_pkg.sv
// Shared definitions for the input conditioner: state encoding and default
// synchroniser/debounce depths.
package condiciona_pkg;

  typedef enum logic [1:0] {
    BAIXO    = 2'b00,
    SUBINDO  = 2'b01,
    ALTO     = 2'b11,
    DESCENDO = 2'b10
  } estado_t;

  localparam int N_SYNC_DEF   = 2;
  localparam int DEBOUNCE_DEF = 4;

endpackage

// File: rtl/condiciona_entrada_if.sv
// Button-side bundle of the input conditioner: raw level in, conditioned
// pulse, debounced level and busy flag out.
interface condiciona_entrada_if;

  logic btn;
  logic pulso;
  logic nivel;
  logic ocupado;

  modport master (output btn, input pulso, nivel, ocupado);
  modport slave  (input btn, output pulso, nivel, ocupado);

endinterface

// File: rtl/sincronizador.sv
// N_SYNC-stage shift-chain synchroniser bringing an asynchronous level into
// the clk domain.
module sincronizador #(
  parameter int N_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N_SYNC-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[N_SYNC-2:0], d};
  end

  assign q = sync_q[N_SYNC-1];

endmodule

// File: rtl/condiciona_entrada.sv
// Synchronises and debounces a raw button level, producing a single-cycle
// pulse per accepted press plus the debounced level and a busy flag.
module condiciona_entrada
  import condiciona_pkg::*;
#(
  parameter int N_SYNC   = N_SYNC_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  condiciona_entrada_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s;
  logic          fim;
  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulso_q, pulso_d;

  sincronizador #(.N_SYNC(N_SYNC)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn),
    .q   (s)
  );

  // The sample being taken now would complete the qualifying run.
  assign fim = (cnt_q + CW'(1)) == CW'(DEBOUNCE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= BAIXO;
      cnt_q    <= '0;
      pulso_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      pulso_q  <= pulso_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    pulso_d  = 1'b0;
    case (estado_q)
      BAIXO: begin
        if (s) begin
          estado_d = SUBINDO;
          cnt_d    = CW'(1);
        end
      end
      SUBINDO: begin
        if (!s) begin
          estado_d = BAIXO;
          cnt_d    = '0;
        end else if (fim) begin
          estado_d = ALTO;
          cnt_d    = '0;
          pulso_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ALTO: begin
        if (!s) begin
          estado_d = DESCENDO;
          cnt_d    = CW'(1);
        end
      end
      DESCENDO: begin
        if (s) begin
          estado_d = ALTO;
          cnt_d    = '0;
        end else if (fim) begin
          estado_d = BAIXO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        estado_d = BAIXO;
        cnt_d    = '0;
      end
    endcase
  end

  assign bus.pulso   = pulso_q;
  assign bus.nivel   = (estado_q == ALTO) || (estado_q == DESCENDO);
  assign bus.ocupado = (estado_q == SUBINDO) || (estado_q == DESCENDO);

endmodule

// File: tb/tb_condiciona_entrada.sv
// Bench for condiciona_entrada: scenario tasks plus a randomized run, all
// compared against a run-length model of the debouncer.
module tb_condiciona_entrada;

  localparam int N_SYNC   = 2;
  localparam int DEBOUNCE = 4;
  localparam int LAT      = N_SYNC + DEBOUNCE;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  condiciona_entrada_if bus ();

  condiciona_entrada #(.N_SYNC(N_SYNC), .DEBOUNCE(DEBOUNCE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: s is btn delayed by N_SYNC samples; the level flips once
  // DEBOUNCE consecutive samples disagree with it, and a rise emits a pulse.
  bit   mq[$];
  bit   m_s;
  bit   m_lvl;
  int   m_run;
  bit   m_pulso;
  logic [2:0] obs;
  logic [2:0] expv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq = {};
      for (int i = 0; i < N_SYNC; i++) mq.push_back(1'b0);
      m_lvl = 1'b0; m_run = 0; m_pulso = 1'b0;
    end else begin
      m_s = mq.pop_front();
      mq.push_back(bus.btn);
      m_pulso = 1'b0;
      if (m_s != m_lvl) begin
        m_run++;
        if (m_run == DEBOUNCE) begin
          m_lvl   = m_s;
          m_run   = 0;
          m_pulso = m_s;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  assign obs  = {bus.pulso, bus.nivel, bus.ocupado};
  assign expv = {m_pulso, m_lvl, (m_run != 0)};

  task automatic idle(input int n);
    bus.btn = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int pulses = 0;
    int first  = -1;
    rst = 1'b1;
    bus.btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 3'b000) $display("FAIL reset_outputs cyc=%0d got=%b want=000", i, obs);
      else n_pass++;
    end
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL reset_release_model e=%0d got=%b want=%b", e, obs, expv);
      else n_pass++;
      if (bus.pulso) begin pulses++; if (first < 0) first = e; end
    end
    n_checks++;
    if (pulses !== 1 || first !== LAT || bus.nivel !== 1'b1)
      $display("FAIL reset_release_pulse got pulses=%0d at=%0d nivel=%b want 1 at %0d nivel=1",
               pulses, first, bus.nivel, LAT);
    else n_pass++;
    idle(15);
  endtask

  task automatic test_clean_press();
    logic [2:0] want;
    bus.btn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      want = {(e == LAT), (e >= LAT), (e >= N_SYNC + 1 && e < LAT)};
      n_checks++;
      if (obs !== want) $display("FAIL clean_press e=%0d got=%b want=%b", e, obs, want);
      else n_pass++;
      n_checks++;
      if (obs !== expv) $display("FAIL clean_press_model e=%0d got=%b want=%b", e, obs, expv);
      else n_pass++;
    end
    bus.btn = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) $display("FAIL clean_release_model e=%0d got=%b want=%b", e, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    bit saw_busy = 1'b0;
    bit saw_bad  = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      bus.btn = (e <= 3);
      @(negedge clk);
      if (bus.ocupado) saw_busy = 1'b1;
      if (bus.pulso || bus.nivel) saw_bad = 1'b1;
      n_checks++;
      if (obs !== expv) $display("FAIL glitch_model e=%0d got=%b want=%b", e, obs, expv);
      else n_pass++;
    end
    n_checks++;
    if (!saw_busy || saw_bad || obs !== 3'b000)
      $display("FAIL glitch_reject got busy=%b pulse_or_level=%b final=%b want busy=1 0 final=000",
               saw_busy, saw_bad, obs);
    else n_pass++;
  endtask

  task automatic test_release_bounce();
    int pulses = 0;
    bus.btn = 1'b1;
    repeat (10) @(negedge clk);
    for (int e = 1; e <= 17; e++) begin
      bus.btn = (e >= 3 && e <= 7);
      @(negedge clk);
      if (bus.pulso) pulses++;
      n_checks++;
      if (bus.nivel !== (e < 8 + LAT - 1))
        $display("FAIL bounce_nivel e=%0d got=%b want=%b", e, bus.nivel, (e < 8 + LAT - 1));
      else n_pass++;
      n_checks++;
      if (obs !== expv) $display("FAIL bounce_model e=%0d got=%b want=%b", e, obs, expv);
      else n_pass++;
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL bounce_pulse got=%0d want=0", pulses);
    else n_pass++;
    idle(5);
  endtask

  task automatic test_repeated();
    int pulses = 0;
    for (int e = 1; e <= 80; e++) begin
      bus.btn = (((e - 1) % 20) < 10);
      @(negedge clk);
      if (bus.pulso) pulses++;
      n_checks++;
      if (bus.pulso !== ((e - LAT) % 20 == 0 && e >= LAT))
        $display("FAIL repeated_pulse e=%0d got=%b want=%b", e, bus.pulso,
                 ((e - LAT) % 20 == 0 && e >= LAT));
      else n_pass++;
      n_checks++;
      if (obs !== expv) $display("FAIL repeated_model e=%0d got=%b want=%b", e, obs, expv);
      else n_pass++;
    end
    n_checks++;
    if (pulses !== 4) $display("FAIL repeated_count got=%0d want=4", pulses);
    else n_pass++;
    idle(5);
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int first  = -1;
    bus.btn = 1'b1;
    repeat (N_SYNC + 2) @(negedge clk);
    n_checks++;
    if (obs !== 3'b001) $display("FAIL mid_subindo got=%b want=001", obs);
    else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.pulso) pulses++;
      n_checks++;
      if (obs !== 3'b000) $display("FAIL mid_reset_outputs cyc=%0d got=%b want=000", i, obs);
      else n_pass++;
    end
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (bus.pulso) begin pulses++; if (first < 0) first = e; end
      n_checks++;
      if (obs !== expv) $display("FAIL mid_release_model e=%0d got=%b want=%b", e, obs, expv);
      else n_pass++;
    end
    n_checks++;
    if (pulses !== 1 || first !== LAT)
      $display("FAIL mid_release_pulse got pulses=%0d at=%0d want 1 at %0d", pulses, first, LAT);
    else n_pass++;
    idle(15);
  endtask

  task automatic test_random();
    int m_pulses = 0;
    int d_pulses = 0;
    for (int seg = 0; seg < 120; seg++) begin
      bus.btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) begin
        @(negedge clk);
        if (bus.pulso) d_pulses++;
        if (m_pulso) m_pulses++;
        n_checks++;
        if (obs !== expv) $display("FAIL random_model seg=%0d got=%b want=%b", seg, obs, expv);
        else n_pass++;
      end
    end
    n_checks++;
    if (d_pulses !== m_pulses) $display("FAIL random_pulse_count got=%0d want=%0d", d_pulses, m_pulses);
    else n_pass++;
    idle(15);
  endtask

  initial begin
    rst = 1'b1;
    bus.btn = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_repeated();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
